// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl shared types, width codes and helpers.
// Imported by the data-memory responder and its bench.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  function automatic logic acc_fault(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic flt;
    flt = 1'b1;
    if (we) begin
      case (f3)
        F3_SB:   flt = 1'b0;
        F3_SH:   flt = lo[0];
        F3_SW:   flt = (lo != 2'd0);
        default: flt = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: flt = 1'b0;
        F3_LH, F3_LHU: flt = lo[0];
        F3_LW:         flt = (lo != 2'd0);
        default:       flt = 1'b1;
      endcase
    end
    return flt;
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [2:0]  f3,
    input logic [1:0]  lo,
    input logic [31:0] word
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LBU:  r = {24'd0, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LHU:  r = {16'd0, h};
      F3_LW:   r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Control-unit to data-memory request/response bundle.
// master = control unit, slave = dmem_ctrl.
interface dmem_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, we, funct3, addr, wdata,
    input  ready, rdata, err, busy
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output ready, rdata, err, busy
  );
endinterface

// File: rtl/dmem_ctrl_array.sv
// Single-port word RAM with byte enables.
// Read address is registered; contents are not reset.
module dmem_ctrl_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr_r;

  // byte-masked write and read-address capture
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      addr_r <= addr;
    end
  end

  assign rdata = mem[addr_r];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder with programmable wait states.
// RV32I byte/half/word loads and stores over req/ready.
import dmem_ctrl_pkg::*;

module dmem_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);

  localparam int AW = ADDR_W + 2;
  localparam logic [3:0] LAT_M1 =
    (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept;
  logic          enter_resp;

  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   hold_q;

  logic          e_we;
  logic [2:0]    e_f3;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wdata;
  logic          e_fault;

  logic [3:0]    be;
  logic [31:0]   lane_d;
  logic          mem_en;
  logic [31:0]   mem_q;

  logic          r_fault;
  logic [31:0]   load_val;
  logic          unused_hi;

  assign unused_hi = ^bus.addr[31:AW];

  // fields seen at the RESP-entry edge: live bus in IDLE
  // (zero-latency accept), latched copy afterwards
  assign e_we    = (state_q == S_IDLE) ? bus.we : we_q;
  assign e_f3    = (state_q == S_IDLE) ? bus.funct3 : f3_q;
  assign e_addr  = (state_q == S_IDLE) ? bus.addr[AW-1:0] : addr_q;
  assign e_wdata = (state_q == S_IDLE) ? bus.wdata : wdata_q;
  assign e_fault = acc_fault(e_we, e_f3, e_addr[1:0]);

  // state and wait counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state and wait-count logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          accept  = 1'b1;
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  // request capture at accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      we_q    <= bus.we;
      f3_q    <= bus.funct3;
      addr_q  <= bus.addr[AW-1:0];
      wdata_q <= bus.wdata;
    end
  end

  // store byte-lane mask and lane-replicated data
  always_comb begin
    be     = 4'b0000;
    lane_d = e_wdata;
    if (e_we && !e_fault) begin
      case (e_f3)
        F3_SB: begin
          be     = 4'b0001 << e_addr[1:0];
          lane_d = {4{e_wdata[7:0]}};
        end
        F3_SH: begin
          be     = e_addr[1] ? 4'b1100 : 4'b0011;
          lane_d = {2{e_wdata[15:0]}};
        end
        F3_SW:   be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
  end

  // reset low suppresses any write, so a pending store is lost
  assign mem_en = enter_resp && rst;

  dmem_ctrl_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .be    (be),
    .addr  (e_addr[AW-1:2]),
    .wdata (lane_d),
    .rdata (mem_q)
  );

  assign r_fault  = acc_fault(we_q, f3_q, addr_q[1:0]);
  assign load_val = (we_q || r_fault) ? 32'd0 :
                    load_ext(f3_q, addr_q[1:0], mem_q);

  // keep the last response visible after ready drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  hold_q <= 32'd0;
    else if (state_q == S_RESP) hold_q <= load_val;
  end

  assign bus.ready = (state_q == S_RESP);
  assign bus.err   = (state_q == S_RESP) && r_fault;
  assign bus.rdata = (state_q == S_RESP) ? load_val : hold_q;
  assign bus.busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: LATENCY=2 and LATENCY=0
// instances, loads/stores, faults, wrap and mid-wait reset.
import dmem_ctrl_pkg::*;

module tb_dmem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  dmem_if bus0();
  dmem_if bus1();

  dmem_ctrl #(.ADDR_W(10), .LATENCY(2)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  dmem_ctrl #(.ADDR_W(10), .LATENCY(0)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic r,
                       input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    if (s == 0) begin
      bus0.req = r; bus0.we = w; bus0.funct3 = f;
      bus0.addr = a; bus0.wdata = d;
    end else begin
      bus1.req = r; bus1.we = w; bus1.funct3 = f;
      bus1.addr = a; bus1.wdata = d;
    end
  endtask

  function automatic logic o_ready(input int s);
    return (s == 0) ? bus0.ready : bus1.ready;
  endfunction

  function automatic logic o_busy(input int s);
    return (s == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic logic o_err(input int s);
    return (s == 0) ? bus0.err : bus1.err;
  endfunction

  function automatic logic [31:0] o_rdata(input int s);
    return (s == 0) ? bus0.rdata : bus1.rdata;
  endfunction

  // one access: accept, scramble inputs, wait for ready,
  // then confirm ready dropped and the unit is idle again
  task automatic acc(input int s, input logic w,
                     input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e,
                     output int cyc);
    logic seen;
    seen = 1'b0;
    rd   = 32'd0;
    e    = 1'b0;
    cyc  = 0;
    @(negedge clk);
    drive(s, 1'b1, w, f, a, d);
    @(posedge clk); #1;
    drive(s, 1'b0, 1'($urandom), 3'($urandom),
          $urandom, $urandom);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (o_ready(s)) begin
        seen = 1'b1;
        rd   = o_rdata(s);
        e    = o_err(s);
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("ready_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    chk("ready_one_cycle", 32'(o_ready(s)), 32'd0);
  endtask

  logic [31:0] rd;
  logic        e;
  int          cyc;
  logic        pulsed;

  initial begin
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    chk("rst_ready", 32'(bus0.ready), 32'd0);
    chk("rst_err", 32'(bus0.err), 32'd0);
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_rdata", bus0.rdata, 32'd0);
    chk("rst_busy1", 32'(bus1.busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    acc(0, 1'b1, F3_SW, 32'h10, 32'hDEADBEEF, rd, e, cyc);
    chk("sw_latency", 32'(cyc), 32'd2);
    chk("sw_err", 32'(e), 32'd0);
    acc(0, 1'b0, F3_LW, 32'h10, 32'h0, rd, e, cyc);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_latency", 32'(cyc), 32'd2);
    chk("rdata_hold", bus0.rdata, 32'hDEADBEEF);
    chk("idle_busy", 32'(bus0.busy), 32'd0);

    acc(0, 1'b1, F3_SB, 32'h11, 32'hAAAAAA55, rd, e, cyc);
    chk("sb_err", 32'(e), 32'd0);
    acc(0, 1'b0, F3_LW, 32'h10, 32'h0, rd, e, cyc);
    chk("sb_word", rd, 32'hDEAD55EF);
    acc(0, 1'b0, F3_LB, 32'h11, 32'h0, rd, e, cyc);
    chk("lb_11", rd, 32'h00000055);
    acc(0, 1'b0, F3_LB, 32'h13, 32'h0, rd, e, cyc);
    chk("lb_13", rd, 32'hFFFFFFDE);
    acc(0, 1'b0, F3_LBU, 32'h13, 32'h0, rd, e, cyc);
    chk("lbu_13", rd, 32'h000000DE);

    acc(0, 1'b1, F3_SH, 32'h12, 32'h12348001, rd, e, cyc);
    chk("sh_err", 32'(e), 32'd0);
    acc(0, 1'b0, F3_LH, 32'h12, 32'h0, rd, e, cyc);
    chk("lh_12", rd, 32'hFFFF8001);
    acc(0, 1'b0, F3_LHU, 32'h12, 32'h0, rd, e, cyc);
    chk("lhu_12", rd, 32'h00008001);
    acc(0, 1'b0, F3_LHU, 32'h10, 32'h0, rd, e, cyc);
    chk("lhu_10_kept", rd, 32'h000055EF);

    acc(0, 1'b0, F3_LW, 32'h13, 32'h0, rd, e, cyc);
    chk("lw_mis_err", 32'(e), 32'd1);
    chk("lw_mis_rdata", rd, 32'd0);
    acc(0, 1'b1, F3_SH, 32'h11, 32'hFFFFFFFF, rd, e, cyc);
    chk("sh_mis_err", 32'(e), 32'd1);
    acc(0, 1'b0, F3_LW, 32'h10, 32'h0, rd, e, cyc);
    chk("sh_mis_nowrite", rd, 32'h800155EF);
    chk("lw_ok_err", 32'(e), 32'd0);
    acc(0, 1'b0, 3'd3, 32'h10, 32'h0, rd, e, cyc);
    chk("ld_f3_3_err", 32'(e), 32'd1);
    chk("ld_f3_3_rdata", rd, 32'd0);
    acc(0, 1'b1, 3'd4, 32'h10, 32'h0, rd, e, cyc);
    chk("st_f3_4_err", 32'(e), 32'd1);
    acc(0, 1'b0, F3_LW, 32'h10, 32'h0, rd, e, cyc);
    chk("st_f3_4_nowrite", rd, 32'h800155EF);

    acc(1, 1'b1, F3_SW, 32'h1004, 32'hCAFEF00D, rd, e, cyc);
    chk("lat0_sw_cyc", 32'(cyc), 32'd0);
    acc(1, 1'b0, F3_LW, 32'h0004, 32'h0, rd, e, cyc);
    chk("wrap_lw", rd, 32'hCAFEF00D);
    chk("lat0_lw_cyc", 32'(cyc), 32'd0);
    acc(1, 1'b0, F3_LB, 32'h0007, 32'h0, rd, e, cyc);
    chk("lat0_lb", rd, 32'hFFFFFFCA);

    acc(0, 1'b1, F3_SW, 32'h20, 32'h11111111, rd, e, cyc);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, F3_SW, 32'h20, 32'h22222222);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    chk("wait_busy", 32'(bus0.busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(bus0.busy), 32'd0);
    chk("arst_ready", 32'(bus0.ready), 32'd0);
    chk("arst_rdata", bus0.rdata, 32'd0);
    pulsed = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      pulsed = pulsed | bus0.ready | bus0.busy;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      pulsed = pulsed | bus0.ready | bus0.busy;
    end
    chk("arst_no_pulse", 32'(pulsed), 32'd0);
    acc(0, 1'b0, F3_LW, 32'h20, 32'h0, rd, e, cyc);
    chk("arst_store_lost", rd, 32'h11111111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
